// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: walks the program ROM from a PC, buffers words in a
// small registered queue and hands them to decode over a valid/ready handshake.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module fetch_ctrl #(
  parameter int unsigned       ADDR_W   = `ADDR_SIZE,
  parameter int unsigned       WORD_W   = `WORD_SIZE,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [7:0]        HALT_OP  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              halted
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [WORD_W-1:0] word_q [DEPTH];
  logic [ADDR_W-1:0] wpc_q  [DEPTH];
  logic [PTR_W-1:0]  rd_q;
  logic [PTR_W-1:0]  wr_q;
  logic [CNT_W-1:0]  count_q;
  logic              halted_q;

  logic pop_c;
  logic push_c;
  logic halt_word_c;

  assign pop_c       = (count_q != '0) && instr_ready;
  assign push_c      = (state_q == FETCH) && fetch_en && !redir_valid &&
                       ((count_q < CNT_W'(DEPTH)) || pop_c);
  // An unknown opcode compares as X and is treated as not-HALT below.
  assign halt_word_c = (rom_data[WORD_W-1 -: 8] == HALT_OP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        word_q[i] <= '0;
        wpc_q[i]  <= '0;
      end
    end else if (redir_valid) begin
      // Redirect flushes everything, including a same-cycle pop.
      pc_q     <= {redir_pc[ADDR_W-1:1], 1'b0};
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      state_q  <= fetch_en ? FETCH : IDLE;
    end else begin
      if (push_c) begin
        word_q[wr_q] <= rom_data;
        wpc_q[wr_q]  <= pc_q;
        wr_q         <= wr_q + PTR_W'(1);
        pc_q         <= pc_q + ADDR_W'(2);
      end
      if (pop_c) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
        count_q <= count_q - CNT_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (fetch_en) state_q <= FETCH;
        end
        FETCH: begin
          if (push_c && halt_word_c) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (!fetch_en) begin
            state_q <= IDLE;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = word_q[rd_q];
  assign instr_pc    = wpc_q[rd_q];
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed phases plus random traffic, checked every cycle
// against a queue-based model of the fetch rules.
module tb_fetch_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned WW    = 16;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned NWORD = 1 << (AW - 1);

  logic          clk;
  logic          rst_n;
  logic          fetch_en;
  logic [AW-1:0] rom_addr;
  logic [WW-1:0] rom_data;
  logic          instr_valid;
  logic [WW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic          redir_valid;
  logic [AW-1:0] redir_pc;
  logic          halted;

  fetch_ctrl #(
    .ADDR_W(AW), .WORD_W(WW), .RESET_PC('0), .DEPTH(DEPTH), .HALT_OP(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .halted(halted)
  );

  logic [WW-1:0] rom [NWORD];
  assign rom_data = rom[rom_addr[AW-1:1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] w;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  bit            m_run;
  bit            m_halt;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    chk("halted", 32'(halted), 32'(m_halt));
    if (mq.size() > 0) begin
      chk("instr", 32'(instr), 32'(mq[0].w));
      chk("instr_pc", 32'(instr_pc), 32'(mq[0].pc));
    end
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, check after the edge.
  task automatic cyc(input bit fe, input bit rdy, input bit rv, input logic [AW-1:0] rpc,
                     input bit rst);
    bit            pop;
    bit            push;
    logic [WW-1:0] w;
    rst_n       = !rst;
    fetch_en    = fe;
    instr_ready = rdy;
    redir_valid = rv;
    redir_pc    = rpc;
    pop = (mq.size() > 0) && rdy;
    if (rst) begin
      mq.delete();
      m_pc = '0; m_run = 0; m_halt = 0;
    end else if (rv) begin
      mq.delete();
      m_pc = {rpc[AW-1:1], 1'b0};
      m_halt = 0;
      m_run = fe;
    end else begin
      push = m_run && fe && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (push) begin
        w = rom[m_pc / 2];
        mq.push_back('{w: w, pc: m_pc});
        m_pc = m_pc + AW'(2);
      end
      if (m_run) begin
        if (push && (w[WW-1 -: 8] === 8'hFF)) begin
          m_run = 0; m_halt = 1;
        end else if (!fe) begin
          m_run = 0;
        end
      end else if (!m_halt && fe) begin
        m_run = 1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic fill_rom();
    int r;
    for (int i = 0; i < int'(NWORD); i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      rom[i] = {8'hFF, 8'($urandom)};
      else if (r == 1) rom[i] = 'x;
      else             rom[i] = {8'($urandom_range(0, 254)), 8'($urandom)};
    end
  endtask

  initial begin
    m_pc = '0; m_run = 0; m_halt = 0;
    for (int i = 0; i < int'(NWORD); i++) rom[i] = 16'h1111 * 16'(i);
    rom[0] = 16'h0000; rom[1] = 16'h0005; rom[2] = 16'h0003;

    // reset state
    cyc(0, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk("reset_instr", 32'(instr), 32'h0);
    chk("reset_instr_pc", 32'(instr_pc), 32'h0);

    // streaming from reset: first valid two cycles after fetch_en
    cyc(1, 1, 0, '0, 0);
    chk("first_not_yet", 32'(instr_valid), 32'h0);
    cyc(1, 1, 0, '0, 0);
    chk("first_word", 32'(instr), 32'h0000);
    cyc(1, 1, 0, '0, 0);
    chk("second_word", 32'(instr), 32'h0005);
    cyc(1, 1, 0, '0, 0);
    chk("third_word", 32'(instr), 32'h0003);
    chk("third_pc", 32'(instr_pc), 32'h4);

    // backpressure: queue fills to DEPTH and pc freezes
    cyc(0, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, '0, 0);
    chk("frozen_addr", 32'(rom_addr), 32'(2 * DEPTH));
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, '0, 0);

    // redirect while full, odd target rounds down
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 1, 4'h5, 0);
    chk("redir_flush", 32'(instr_valid), 32'h0);
    cyc(1, 1, 0, '0, 0);
    chk("redir_target_pc", 32'(instr_pc), 32'h4);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, '0, 0);

    // HALT word at address 6, then restart by redirect
    rom[3] = 16'hFF00;
    cyc(1, 1, 1, 4'h0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, '0, 0);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_addr", 32'(rom_addr), 32'h8);
    cyc(0, 1, 0, '0, 0);
    cyc(1, 1, 0, '0, 0);
    cyc(1, 1, 1, 4'h0, 0);
    chk("halt_cleared", 32'(halted), 32'h0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, '0, 0);

    // pc wraps from 0xE back to 0x0
    rom[3] = 16'h1234; rom[7] = 16'h7777;
    cyc(1, 1, 1, 4'hC, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, '0, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) fill_rom();
      cyc(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
          ($urandom_range(0, 11) == 0), AW'($urandom),
          ($urandom_range(0, 59) == 0));
    end

    // reset mid-stream with a full queue
    rom[3] = 16'h0033;
    cyc(1, 0, 1, 4'h0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 1);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_addr", 32'(rom_addr), 32'h0);
    cyc(0, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    chk("rst_idle", 32'(instr_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
